cp_writeback: RTL and testbench
===============================

CP_WRITEBACK -- requirements
Module: cp_writeback

Interface
REQ-001 SHALL take DATA_W from `DEF_CP_DATA_WIDTH (default 32): the datapath width.
REQ-002 SHALL take RIDX_W from `DEF_CP_RF_INDEX_WIDTH (default 5): the RF index width.
REQ-003 SHALL have port iClk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port iReset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port iEX_Valid, input, 1: the EX-stage instruction is valid.
REQ-006 SHALL have port iEX_Write_Enable, input, 1: the EX instruction writes the RF.
REQ-007 SHALL have port iEX_Write_Addr, input, RIDX_W: the EX destination register.
REQ-008 SHALL have port iEX_ALU_Result, input, DATA_W: the ALU result, or the load address for loads.
REQ-009 SHALL have port iEX_Is_Load, input, 1: the EX instruction is a load.
REQ-010 SHALL have port iEX_Load_Size, input, 2: load size; 00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 SHALL have port iEX_Load_Signed, input, 1: sign-extend the load (0 = zero-extend).
REQ-012 SHALL have port iLSU_Read_Data, input, DATA_W: the data-memory response word.
REQ-013 SHALL have port iLSU_Read_Valid, input, 1: the response is valid this cycle.
REQ-014 SHALL have ports oEX_RF_Write_Addr, oEX_RF_Write_Data and oEX_RF_Write_Enable, outputs, RIDX_W/DATA_W/1: the EX forwarding source for the bypass network.
REQ-015 SHALL have ports oWB_RF_Write_Addr, oWB_RF_Write_Data and oWB_RF_Write_Enable, outputs, RIDX_W/DATA_W/1: the RF write port, which also feeds the bypass.
REQ-016 SHALL have port oEX_Load_Pending, input-side hazard flag, output, 1: the EX instruction is a load with rd≠0, so the hazard unit stalls a load-use.
REQ-017 SHALL have port oStall, output, 1: freezes IF/ID/EX.

Function
REQ-018 SHALL drive oEX_RF_Write_Enable = iEX_Valid & iEX_Write_Enable & ~iEX_Is_Load & (iEX_Write_Addr≠0), combinationally.
REQ-019 SHALL drive oEX_RF_Write_Data = iEX_ALU_Result and oEX_RF_Write_Addr = iEX_Write_Addr.
REQ-020 SHALL capture the EX fields into the WB registers at each edge with oStall=0; while oStall=1 the WB registers SHALL hold.
REQ-021 SHALL capture an invalid EX instruction as a WB bubble: the valid bit is cleared and no write occurs.
REQ-022 SHALL use an FSM with states IDLE and LOAD_WAIT.
REQ-023 In IDLE, a WB non-load with the write flag set and rd≠0 SHALL assert oWB_RF_Write_Enable for exactly one cycle, with data = the registered ALU result (one-cycle latency from EX).
REQ-024 In IDLE, a WB load with iLSU_Read_Valid=1 SHALL write the formatted data in the same cycle and stay in IDLE.
REQ-025 In IDLE, a WB load with iLSU_Read_Valid=0 SHALL go to LOAD_WAIT; oStall=1 combinationally that cycle and oWB_RF_Write_Enable=0.
REQ-026 In LOAD_WAIT, oStall SHALL remain 1 until iLSU_Read_Valid=1; in that cycle the formatted data SHALL be written, oStall=0, and the next state SHALL be IDLE.
REQ-027 SHALL ignore iLSU_Read_Valid when no load is in WB: no write and no state change.
REQ-028 SHALL still complete the stall/response handshake for a load to rd=0, but with no RF write.
REQ-029 Formatting: lane = registered address[1:0], little-endian.
REQ-030 Byte loads SHALL select bits [8·lane+7 : 8·lane].
REQ-031 Half loads SHALL select the half indicated by address[1], ignoring address[0].
REQ-032 Word loads SHALL ignore the offset.
REQ-033 Narrow loads SHALL be extended to DATA_W per the signed flag.
REQ-034 SHALL drive no WB write to register 0 under any condition.

Reset
REQ-035 While iReset=1, the state SHALL be IDLE, all WB registers 0, and oWB_RF_Write_Enable=0 and oStall=0.
REQ-036 Reset during LOAD_WAIT SHALL abandon the load; a response arriving after reset SHALL be ignored per REQ-027.
REQ-037 The oEX_* outputs SHALL remain combinational and unaffected by reset.

Structure
REQ-038 DATA_W, RIDX_W, the load-size encodings and the FSM state encodings SHALL reside in the shared def-cp definitions file.
REQ-039 Load alignment and extension SHALL be one combinational sub-module, cp_load_align.

Verification
REQ-040 ADD r3, ALU=0x12345678, valid → EX bypass enable=1 same cycle; WB write r3=0x12345678 next cycle for 1 cycle.
REQ-041 LB signed r4, addr=0x...2, response 0x00A50000 valid at WB → r4=0xFFFFFFA5, no stall.
REQ-042 LHU r5, addr=0x...3, response 0x80010000 delayed 3 cycles → oStall=1 for 3 cycles, then r5=0x00008001, IDLE.
REQ-043 Write to r0 (ALU and load) → oWB_RF_Write_Enable never 1; the load still waits for its response.
REQ-044 Reset asserted mid-LOAD_WAIT, response arrives after deassert → no write, oStall=0.
REQ-045 Spurious iLSU_Read_Valid with a non-load/bubble in WB → outputs unchanged, state IDLE.

Source files
------------

// File: rtl/cp_writeback_pkg.sv
// Shared def-cp definitions: datapath widths, load-size codes and writeback FSM states.
`ifndef DEF_CP_DATA_WIDTH
`define DEF_CP_DATA_WIDTH 32
`endif
`ifndef DEF_CP_RF_INDEX_WIDTH
`define DEF_CP_RF_INDEX_WIDTH 5
`endif

package cp_writeback_pkg;

  localparam int unsigned CP_DATA_W = `DEF_CP_DATA_WIDTH;
  localparam int unsigned CP_RIDX_W = `DEF_CP_RF_INDEX_WIDTH;

  typedef enum logic [1:0] {
    LS_BYTE     = 2'b00,
    LS_HALF     = 2'b01,
    LS_WORD     = 2'b10,
    LS_WORD_ALT = 2'b11
  } loadSize_e;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wbState_e;

endpackage

// File: rtl/cp_load_align.sv
// Little-endian lane select and sign/zero extension of a data-memory response word.
module cp_load_align
  import cp_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = CP_DATA_W
) (
  input  logic [DATA_W-1:0] iRead_Data,
  input  logic [1:0]        iLane,
  input  logic [1:0]        iSize,
  input  logic              iSigned,
  output logic [DATA_W-1:0] oData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = iRead_Data[{iLane, 3'b000} +: 8];
    // Half loads only look at lane[1]; a misaligned lane[0] is ignored.
    halfSel = iRead_Data[{iLane[1], 4'b0000} +: 16];
    case (loadSize_e'(iSize))
      LS_BYTE: oData = {{(DATA_W-8){iSigned & byteSel[7]}}, byteSel};
      LS_HALF: oData = {{(DATA_W-16){iSigned & halfSel[15]}}, halfSel};
      default: oData = iRead_Data;
    endcase
  end

endmodule

// File: rtl/cp_writeback.sv
// Writeback stage: EX bypass source, WB register, and the load-response stall handshake.
module cp_writeback
  import cp_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = CP_DATA_W,
  parameter int unsigned RIDX_W = CP_RIDX_W
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iEX_Valid,
  input  logic              iEX_Write_Enable,
  input  logic [RIDX_W-1:0] iEX_Write_Addr,
  input  logic [DATA_W-1:0] iEX_ALU_Result,
  input  logic              iEX_Is_Load,
  input  logic [1:0]        iEX_Load_Size,
  input  logic              iEX_Load_Signed,
  input  logic [DATA_W-1:0] iLSU_Read_Data,
  input  logic              iLSU_Read_Valid,
  output logic [RIDX_W-1:0] oEX_RF_Write_Addr,
  output logic [DATA_W-1:0] oEX_RF_Write_Data,
  output logic              oEX_RF_Write_Enable,
  output logic [RIDX_W-1:0] oWB_RF_Write_Addr,
  output logic [DATA_W-1:0] oWB_RF_Write_Data,
  output logic              oWB_RF_Write_Enable,
  output logic              oEX_Load_Pending,
  output logic              oStall
);

  wbState_e          state, stateNext;
  logic              wbValid, wbWe, wbIsLoad, wbSigned;
  logic [RIDX_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbResult;
  logic [1:0]        wbSize;
  logic [DATA_W-1:0] loadData;
  logic              wbWriteOk;

  assign oEX_RF_Write_Enable = iEX_Valid & iEX_Write_Enable & ~iEX_Is_Load
                             & (iEX_Write_Addr != '0);
  assign oEX_RF_Write_Data   = iEX_ALU_Result;
  assign oEX_RF_Write_Addr   = iEX_Write_Addr;
  assign oEX_Load_Pending    = iEX_Valid & iEX_Is_Load & (iEX_Write_Addr != '0);

  assign wbWriteOk          = wbWe & (wbAddr != '0);
  assign oWB_RF_Write_Addr  = wbAddr;
  assign oWB_RF_Write_Data  = wbIsLoad ? loadData : wbResult;

  cp_load_align #(.DATA_W(DATA_W)) uAlign (
    .iRead_Data (iLSU_Read_Data),
    .iLane      (wbResult[1:0]),
    .iSize      (wbSize),
    .iSigned    (wbSigned),
    .oData      (loadData)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wbValid  <= 1'b0;
      wbWe     <= 1'b0;
      wbAddr   <= '0;
      wbResult <= '0;
      wbIsLoad <= 1'b0;
      wbSize   <= '0;
      wbSigned <= 1'b0;
    end else if (!oStall) begin
      wbValid  <= iEX_Valid;
      wbWe     <= iEX_Valid & iEX_Write_Enable;
      wbAddr   <= iEX_Write_Addr;
      wbResult <= iEX_ALU_Result;
      wbIsLoad <= iEX_Is_Load;
      wbSize   <= iEX_Load_Size;
      wbSigned <= iEX_Load_Signed;
    end
  end

  always_comb begin
    stateNext           = state;
    oStall              = 1'b0;
    oWB_RF_Write_Enable = 1'b0;
    case (state)
      IDLE: begin
        if (wbValid) begin
          if (!wbIsLoad) begin
            oWB_RF_Write_Enable = wbWriteOk;
          end else if (iLSU_Read_Valid) begin
            oWB_RF_Write_Enable = wbWriteOk;
          end else begin
            oStall    = 1'b1;
            stateNext = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        if (iLSU_Read_Valid) begin
          oWB_RF_Write_Enable = wbWriteOk;
          stateNext           = IDLE;
        end else begin
          oStall = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp_writeback.sv
// Bench for cp_writeback: directed vector table, reset corner sequence, random run against a slot model.
module tb_cp_writeback;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          iClk = 1'b0;
  logic          iReset;
  logic          iEX_Valid, iEX_Write_Enable, iEX_Is_Load, iEX_Load_Signed, iLSU_Read_Valid;
  logic [AW-1:0] iEX_Write_Addr;
  logic [DW-1:0] iEX_ALU_Result, iLSU_Read_Data;
  logic [1:0]    iEX_Load_Size;
  logic [AW-1:0] oEX_RF_Write_Addr, oWB_RF_Write_Addr;
  logic [DW-1:0] oEX_RF_Write_Data, oWB_RF_Write_Data;
  logic          oEX_RF_Write_Enable, oWB_RF_Write_Enable, oEX_Load_Pending, oStall;

  always #5 iClk = ~iClk;

  cp_writeback #(.DATA_W(DW), .RIDX_W(AW)) dut (
    .iClk                (iClk),
    .iReset              (iReset),
    .iEX_Valid           (iEX_Valid),
    .iEX_Write_Enable    (iEX_Write_Enable),
    .iEX_Write_Addr      (iEX_Write_Addr),
    .iEX_ALU_Result      (iEX_ALU_Result),
    .iEX_Is_Load         (iEX_Is_Load),
    .iEX_Load_Size       (iEX_Load_Size),
    .iEX_Load_Signed     (iEX_Load_Signed),
    .iLSU_Read_Data      (iLSU_Read_Data),
    .iLSU_Read_Valid     (iLSU_Read_Valid),
    .oEX_RF_Write_Addr   (oEX_RF_Write_Addr),
    .oEX_RF_Write_Data   (oEX_RF_Write_Data),
    .oEX_RF_Write_Enable (oEX_RF_Write_Enable),
    .oWB_RF_Write_Addr   (oWB_RF_Write_Addr),
    .oWB_RF_Write_Data   (oWB_RF_Write_Data),
    .oWB_RF_Write_Enable (oWB_RF_Write_Enable),
    .oEX_Load_Pending    (oEX_Load_Pending),
    .oStall              (oStall)
  );

  typedef struct {
    bit        valid, we;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit        ld;
    bit [1:0]  size;
    bit        sgn;
    bit [31:0] rdata;
    bit        rvalid;
    bit        rst;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit        exWe, pend, wbWe;
    bit [4:0]  wbAddr;
    bit [31:0] wbData;
    bit        stall;
  } vec_t;

  // Model: the instruction occupying WB, as the pipeline would see it.
  typedef struct {
    bit        valid, we;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit        ld;
    bit [1:0]  size;
    bit        sgn;
  } slot_t;

  int unsigned nCompared = 0;
  int unsigned nMismatched = 0;
  stim_t cur;
  slot_t slot;
  vec_t  tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] fmtLoad(bit [31:0] word, bit [31:0] addr, bit [1:0] size, bit sgn);
    bit [31:0] v;
    case (size)
      2'd0: begin
        v = (word >> ((addr % 4) * 8)) % 256;
        if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (((addr / 2) % 2) * 16)) % 65536;
        if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic stim_t st(bit v, bit we, bit [4:0] rd, bit [31:0] alu, bit ld, bit [1:0] sz,
                               bit sg, bit [31:0] rdata, bit rv);
    stim_t s;
    s = '{valid: v, we: we, rd: rd, alu: alu, ld: ld, size: sz, sgn: sg,
          rdata: rdata, rvalid: rv, rst: 1'b0};
    return s;
  endfunction

  function automatic vec_t vx(stim_t s, bit exWe, bit pend, bit wbWe, bit [4:0] wa, bit [31:0] wd, bit stall);
    vec_t r;
    r = '{s: s, exWe: exWe, pend: pend, wbWe: wbWe, wbAddr: wa, wbData: wd, stall: stall};
    return r;
  endfunction

  task automatic apply(input stim_t s);
    cur              = s;
    iEX_Valid        = s.valid;
    iEX_Write_Enable = s.we;
    iEX_Write_Addr   = s.rd;
    iEX_ALU_Result   = s.alu;
    iEX_Is_Load      = s.ld;
    iEX_Load_Size    = s.size;
    iEX_Load_Signed  = s.sgn;
    iLSU_Read_Data   = s.rdata;
    iLSU_Read_Valid  = s.rvalid;
    iReset           = s.rst;
    if (s.rst) slot = '{default: 0};
  endtask

  function automatic bit expStallNow();
    return slot.valid && slot.ld && !cur.rvalid;
  endfunction

  task automatic checkModel();
    bit        expExWe, expPend, expWbWe;
    bit [31:0] expData;
    expExWe = cur.valid && cur.we && !cur.ld && cur.rd != 0;
    expPend = cur.valid && cur.ld && cur.rd != 0;
    expWbWe = slot.valid && slot.we && slot.rd != 0 && (!slot.ld || cur.rvalid);
    expData = slot.ld ? fmtLoad(cur.rdata, slot.alu, slot.size, slot.sgn) : slot.alu;
    check("m.exWe", oEX_RF_Write_Enable, expExWe);
    check("m.exData", oEX_RF_Write_Data, cur.alu);
    check("m.exAddr", oEX_RF_Write_Addr, cur.rd);
    check("m.loadPending", oEX_Load_Pending, expPend);
    check("m.stall", oStall, expStallNow());
    check("m.wbWe", oWB_RF_Write_Enable, expWbWe);
    if (expWbWe) begin
      check("m.wbAddr", oWB_RF_Write_Addr, slot.rd);
      check("m.wbData", oWB_RF_Write_Data, expData);
    end
  endtask

  task automatic clockEdge();
    bit hold;
    hold = expStallNow();
    @(posedge iClk);
    if (iReset) slot = '{default: 0};
    else if (!hold)
      slot = '{valid: cur.valid, we: cur.valid && cur.we, rd: cur.rd, alu: cur.alu,
               ld: cur.ld, size: cur.size, sgn: cur.sgn};
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t b, s;
    b = st(0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(vx(st(1, 1, 3, 32'h1234_5678, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0));
    tbl.push_back(vx(b,                                         0, 0, 1, 3, 32'h1234_5678, 0));
    tbl.push_back(vx(st(1, 1, 4, 32'h0000_1002, 1, 0, 1, 0, 0), 0, 1, 0, 0, 0, 0));
    tbl.push_back(vx(st(0, 0, 0, 0, 0, 0, 0, 32'h00A5_0000, 1), 0, 0, 1, 4, 32'hFFFF_FFA5, 0));
    tbl.push_back(vx(st(1, 1, 5, 32'h0000_2003, 1, 1, 0, 0, 0), 0, 1, 0, 0, 0, 0));
    tbl.push_back(vx(st(1, 1, 6, 32'h0000_AAAA, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 1));
    tbl.push_back(vx(st(1, 1, 6, 32'h0000_AAAA, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 1));
    tbl.push_back(vx(st(1, 1, 6, 32'h0000_AAAA, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 1));
    tbl.push_back(vx(st(1, 1, 6, 32'h0000_AAAA, 0, 0, 0, 32'h8001_0000, 1), 1, 0, 1, 5, 32'h0000_8001, 0));
    tbl.push_back(vx(st(0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 1), 0, 0, 1, 6, 32'h0000_AAAA, 0));
    tbl.push_back(vx(st(0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 1), 0, 0, 0, 0, 0, 0));
    tbl.push_back(vx(st(1, 1, 0, 32'h0000_0055, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0));
    tbl.push_back(vx(st(1, 1, 0, 32'h0000_0000, 1, 2, 0, 0, 0), 0, 0, 0, 0, 0, 0));
    tbl.push_back(vx(b,                                         0, 0, 0, 0, 0, 1));
    tbl.push_back(vx(st(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1), 0, 0, 0, 0, 0, 0));
    tbl.push_back(vx(b,                                         0, 0, 0, 0, 0, 0));

    // Reset state
    s = b; s.rst = 1;
    apply(s);
    repeat (2) @(posedge iClk);
    #1;
    check("reset.wbWe", oWB_RF_Write_Enable, 0);
    check("reset.stall", oStall, 0);
    check("reset.wbAddr", oWB_RF_Write_Addr, 0);
    check("reset.wbData", oWB_RF_Write_Data, 0);
    slot = '{default: 0};

    // Directed table
    foreach (tbl[i]) begin
      apply(tbl[i].s);
      #3;
      check($sformatf("tbl[%0d].exWe", i), oEX_RF_Write_Enable, tbl[i].exWe);
      check($sformatf("tbl[%0d].pend", i), oEX_Load_Pending, tbl[i].pend);
      check($sformatf("tbl[%0d].wbWe", i), oWB_RF_Write_Enable, tbl[i].wbWe);
      check($sformatf("tbl[%0d].stall", i), oStall, tbl[i].stall);
      if (tbl[i].wbWe) begin
        check($sformatf("tbl[%0d].wbAddr", i), oWB_RF_Write_Addr, tbl[i].wbAddr);
        check($sformatf("tbl[%0d].wbData", i), oWB_RF_Write_Data, tbl[i].wbData);
      end
      checkModel();
      clockEdge();
    end

    // Reset in the middle of a load wait, response arriving after release
    apply(st(1, 1, 7, 32'h0000_0000, 1, 2, 0, 0, 0));
    #3; checkModel(); clockEdge();
    apply(b);
    #3;
    check("rstWait.stallBefore", oStall, 1);
    iReset = 1'b1;
    cur.rst = 1'b1;
    slot = '{default: 0};
    #1;
    check("rstWait.stallAsync", oStall, 0);
    check("rstWait.wbWeAsync", oWB_RF_Write_Enable, 0);
    clockEdge();
    apply(st(0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 1));
    #3;
    check("rstWait.lateRespWe", oWB_RF_Write_Enable, 0);
    check("rstWait.lateRespStall", oStall, 0);
    checkModel(); clockEdge();
    apply(st(0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0));
    #3;
    check("rstWait.idleAfter", oStall, 0);
    checkModel(); clockEdge();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s.valid  = ($urandom % 4) != 0;
      s.we     = ($urandom % 5) != 0;
      s.rd     = 5'($urandom % 8);
      s.alu    = $urandom;
      s.ld     = ($urandom % 2) != 0;
      s.size   = 2'($urandom);
      s.sgn    = ($urandom % 2) != 0;
      s.rdata  = $urandom;
      s.rvalid = ($urandom % 3) != 0;
      s.rst    = ($urandom % 150) == 0;
      apply(s);
      #3;
      checkModel();
      clockEdge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
